mul_arbiter: RTL and testbench

Round-robin arbiter and result scheduler that shares one instance of the team's combinational 32x32 signed radix-4 Booth multiplier (`mul`) among `N_REQ` requesters. Each requester issues operand pairs over a valid/ready handshake. A single response channel returns the 64-bit product together with the requester index. It sits between the execution-unit clients and the multiplier datapath and registers the product to break the long combinational path.

---
 rtl/mul_arbiter_if.sv | 26 ++
 rtl/mul_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mul_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: request and response channels of the shared-multiplier
// arbiter. The master side is the requester/consumer population; the slave
// side is the arbiter. Clock and reset are kept outside the interface.
interface mul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid_i;
  logic [N_REQ-1:0]    req_ready_o;
  logic [32*N_REQ-1:0] req_a_i;
  logic [32*N_REQ-1:0] req_b_i;
  logic                resp_valid_o;
  logic                resp_ready_i;
  logic [ID_W-1:0]     resp_id_o;
  logic [63:0]         resp_product_o;

  modport master (
    output req_valid_i, req_a_i, req_b_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_id_o, resp_product_o
  );

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_id_o, resp_product_o
  );
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter sharing one signed 32x32 radix-4 Booth
// multiplier among N_REQ requesters, with a registered 64-bit response.
// Optional macro MUL_ARB_PIPE_EN adds an operand/ID register stage in front
// of the multiplier (latency 2 instead of 1).
// IDLE/BUSY are implied by the stage valid flags; no separate state register.
module mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mul_arbiter_if.slave bus
);

  // Signed 32x32 -> 64 product by radix-4 Booth recoding of b.
  // Each 3-bit window {b[2i+1], b[2i], b[2i-1]} selects 0, +-a or +-2a.
  function automatic logic [63:0] booth_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] a_ext;
    logic [63:0] pp;
    logic [63:0] acc;
    logic [32:0] b_ext;
    logic [2:0]  grp;
    a_ext = {{32{a[31]}}, a};
    b_ext = {b, 1'b0};
    acc   = 64'd0;
    for (int i = 0; i < 16; i++) begin
      grp = b_ext[2*i +: 3];
      case (grp)
        3'b000, 3'b111: pp = 64'd0;
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = 64'd0;
      endcase
      acc = acc + (pp << (2*i));
    end
    return acc;
  endfunction

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic [63:0]      resp_prod_q, resp_prod_d;

  logic [N_REQ-1:0] grant_s;
  logic [ID_W-1:0]  gnt_id_s;
  logic             gnt_found_s;
  logic [ID_W:0]    scan_idx_s;
  logic             accept_en_s;
  logic             xfer_s;
  logic [31:0]      a_mux_s;
  logic [31:0]      b_mux_s;
  logic [63:0]      mul_out_s;

`ifdef MUL_ARB_PIPE_EN
  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_a_q, s1_a_d;
  logic [31:0]      s1_b_q, s1_b_d;
  logic [ID_W-1:0]  s1_id_q, s1_id_d;
  logic             s1_adv_s;
`endif

  // Round-robin search: first valid index at or after rr_ptr, wrapping to 0.
  always_comb begin
    grant_s     = '0;
    gnt_id_s    = '0;
    gnt_found_s = 1'b0;
    scan_idx_s  = '0;
    for (int off = 0; off < N_REQ; off++) begin
      scan_idx_s = {1'b0, rr_ptr_q} + (ID_W+1)'(off);
      if (scan_idx_s >= (ID_W+1)'(N_REQ)) begin
        scan_idx_s = scan_idx_s - (ID_W+1)'(N_REQ);
      end else begin
        scan_idx_s = scan_idx_s;
      end
      if (!gnt_found_s && bus.req_valid_i[scan_idx_s[ID_W-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_id_s    = scan_idx_s[ID_W-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
    grant_s[gnt_id_s] = gnt_found_s;
  end

  // Accept enable: the stage being written is empty or is being drained.
  // resp_ready_i reaches only the ready/enable logic, never the operand mux.
  always_comb begin
`ifdef MUL_ARB_PIPE_EN
    s1_adv_s    = !resp_valid_q || bus.resp_ready_i;
    accept_en_s = !s1_valid_q || s1_adv_s;
`else
    accept_en_s = !resp_valid_q || bus.resp_ready_i;
`endif
  end

  assign xfer_s          = gnt_found_s & accept_en_s;
  assign bus.req_ready_o = grant_s & {N_REQ{accept_en_s & ~rst_i}};

  assign a_mux_s = bus.req_a_i[32*gnt_id_s +: 32];
  assign b_mux_s = bus.req_b_i[32*gnt_id_s +: 32];

`ifdef MUL_ARB_PIPE_EN
  assign mul_out_s = booth_mul(s1_a_q, s1_b_q);
`else
  assign mul_out_s = booth_mul(a_mux_s, b_mux_s);
`endif

  // Next-state: pointer advances past the granted index on a transfer;
  // response loads a new result (replacing a draining one) or clears on drain.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_prod_d  = resp_prod_q;
    if (xfer_s) begin
      if (gnt_id_s == ID_W'(N_REQ-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_id_s + ID_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
`ifdef MUL_ARB_PIPE_EN
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    if (s1_adv_s) begin
      resp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        resp_id_d   = s1_id_q;
        resp_prod_d = mul_out_s;
      end else begin
        resp_id_d   = resp_id_q;
      end
    end else begin
      resp_valid_d = resp_valid_q;
    end
    if (xfer_s) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a_mux_s;
      s1_b_d     = b_mux_s;
      s1_id_d    = gnt_id_s;
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
`else
    if (xfer_s) begin
      resp_valid_d = 1'b1;
      resp_id_d    = gnt_id_s;
      resp_prod_d  = mul_out_s;
    end else if (bus.resp_ready_i) begin
      resp_valid_d = 1'b0;
    end else begin
      resp_valid_d = resp_valid_q;
    end
`endif
  end

  // State registers; reset drops every in-flight result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_prod_q  <= 64'd0;
`ifdef MUL_ARB_PIPE_EN
      s1_valid_q   <= 1'b0;
      s1_a_q       <= 32'd0;
      s1_b_q       <= 32'd0;
      s1_id_q      <= '0;
`endif
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_prod_q  <= resp_prod_d;
`ifdef MUL_ARB_PIPE_EN
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_id_q      <= s1_id_d;
`endif
    end
  end

  assign bus.resp_valid_o   = resp_valid_q;
  assign bus.resp_id_o      = resp_id_q;
  assign bus.resp_product_o = resp_prod_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed table vectors, multi-cycle corner sequences and a
// random stress phase, checked against a reference round-robin/product model.
module tb_mul_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
`ifdef MUL_ARB_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_arbiter_if #(.N_REQ(N), .ID_W(IW)) bus();
  mul_arbiter #(.N_REQ(N), .ID_W(IW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [1:0] id; logic [31:0] a; logic [31:0] b; logic [63:0] prod; } vec_t;
  typedef struct { logic [1:0] id; logic [63:0] prod; } exp_t;

  vec_t       vecs[8];
  exp_t       expq[$];
  logic [N-1:0] xfer_seen = '0;
  int         wait_cnt[N];
  logic [1:0] m_ptr = 2'd0;
  int         n_resp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Reference model sampled at negedge, where inputs are stable for the next edge.
  always @(negedge clk) begin
    logic         found;
    int           g;
    int           idx;
    logic         acc;
    logic [N-1:0] exp_rdy;
    exp_t         e;
    logic [31:0]  a;
    logic [31:0]  b;
    if (rst) begin
      m_ptr = 2'd0;
      expq.delete();
      xfer_seen = '0;
      for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    end else begin
      found = 1'b0;
      g = 0;
      for (int o = 0; o < N; o++) begin
        idx = (int'(m_ptr) + o) % N;
        if (!found && bus.req_valid_i[idx]) begin
          found = 1'b1;
          g = idx;
        end
      end
      acc = (expq.size() < LAT) || bus.resp_ready_i;
      exp_rdy = (found && acc) ? oh(g) : '0;
      chk("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
      xfer_seen = bus.req_valid_i & bus.req_ready_o;
      if (bus.resp_valid_o && bus.resp_ready_i) begin
        if (expq.size() == 0) begin
          chk("resp_unexpected", 64'd1, 64'd0);
        end else begin
          e = expq.pop_front();
          chk("resp_id", 64'(bus.resp_id_o), 64'(e.id));
          chk("resp_product", bus.resp_product_o, e.prod);
          n_resp++;
        end
      end
      if (found && acc) begin
        a = bus.req_a_i[32*g +: 32];
        b = bus.req_b_i[32*g +: 32];
        e.id   = 2'(g);
        e.prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        expq.push_back(e);
        for (int k = 0; k < N; k++) begin
          if (k == g) begin
            wait_cnt[k] = 0;
          end else if (bus.req_valid_i[k]) begin
            wait_cnt[k]++;
            chk("starvation", 64'(wait_cnt[k] > N), 64'd0);
          end else begin
            wait_cnt[k] = 0;
          end
        end
        m_ptr = 2'((g + 1) % N);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n0;
    int seq[6];
    seq = '{0, 1, 2, 3, 0, 1};
    vecs[0] = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[2] = '{2'd1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
    vecs[3] = '{2'd3, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
    vecs[4] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[5] = '{2'd1, 32'h1234_5678, 32'h0000_0002, 64'h0000_0000_2468_ACF0};
    vecs[6] = '{2'd0, 32'hFFFF_FFFB, 32'h0000_0064, 64'hFFFF_FFFF_FFFF_FE0C};
    vecs[7] = '{2'd3, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};

    bus.req_valid_i  = 4'hF;
    bus.req_a_i      = '0;
    bus.req_b_i      = '0;
    bus.resp_ready_i = 1'b1;
    #2;
    chk("reset_ready", 64'(bus.req_ready_o), 64'd0);
    chk("reset_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("reset_resp_id", 64'(bus.resp_id_o), 64'd0);
    chk("reset_resp_product", bus.resp_product_o, 64'd0);
    bus.req_valid_i = '0;
    #20;
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven single requests, one at a time.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.req_a_i[32*vecs[i].id +: 32] = vecs[i].a;
      bus.req_b_i[32*vecs[i].id +: 32] = vecs[i].b;
      bus.req_valid_i = oh(int'(vecs[i].id));
      #1;
      chk($sformatf("vec%0d_ready", i), 64'(bus.req_ready_o), 64'(oh(int'(vecs[i].id))));
      @(posedge clk); #1;
      bus.req_valid_i = '0;
      cyc = 1;
      while (!bus.resp_valid_o && cyc < 8) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk($sformatf("vec%0d_latency", i), 64'(cyc), 64'(LAT));
      chk($sformatf("vec%0d_id", i), 64'(bus.resp_id_o), 64'(vecs[i].id));
      chk($sformatf("vec%0d_product", i), bus.resp_product_o, vecs[i].prod);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_release", i), 64'(bus.resp_valid_o), 64'd0);
    end

    // Backpressure: requesters 1 and 3, consumer stalled for 5 cycles.
    @(posedge clk); #1;
    n0 = n_resp;
    bus.resp_ready_i = 1'b0;
    bus.req_a_i[32*1 +: 32] = 32'hFFFF_FFFE;
    bus.req_b_i[32*1 +: 32] = 32'h0000_0003;
    bus.req_a_i[32*3 +: 32] = 32'h0000_0064;
    bus.req_b_i[32*3 +: 32] = 32'hFFFF_FF9C;
    bus.req_valid_i = 4'b1010;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      bus.req_valid_i = bus.req_valid_i & ~xfer_seen;
      #1;
      if (c >= LAT) begin
        chk("bp_resp_valid", 64'(bus.resp_valid_o), 64'd1);
        chk("bp_resp_id", 64'(bus.resp_id_o), 64'd1);
        chk("bp_resp_product", bus.resp_product_o, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("bp_ready_zero", 64'(bus.req_ready_o), 64'd0);
      end
    end
    bus.resp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = bus.req_valid_i & ~xfer_seen;
    chk("bp_no_bubble_valid", 64'(bus.resp_valid_o), 64'd1);
    chk("bp_no_bubble_id", 64'(bus.resp_id_o), 64'd3);
    cyc = 0;
    while ((expq.size() != 0 || bus.req_valid_i != '0 || bus.resp_valid_o) && cyc < 20) begin
      @(posedge clk); #1;
      bus.req_valid_i = bus.req_valid_i & ~xfer_seen;
      cyc++;
    end
    chk("bp_drain_count", 64'(n_resp - n0), 64'd2);
    chk("bp_drain_done", 64'(bus.resp_valid_o), 64'd0);

    // Fairness: all requesters held valid, consumer always ready.
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      bus.req_a_i[32*k +: 32] = 32'(k + 1);
      bus.req_b_i[32*k +: 32] = 32'(1000 + k);
    end
    bus.req_valid_i = 4'hF;
    for (int i = 0; i < 6 + LAT; i++) begin
      if (i < 6) begin
        #1;
        chk($sformatf("fair_ready%0d", i), 64'(bus.req_ready_o), 64'(oh(seq[i])));
      end
      @(posedge clk); #1;
      if (i + 1 >= LAT && i + 1 - LAT < 6) begin
        chk("fair_resp_valid", 64'(bus.resp_valid_o), 64'd1);
        chk($sformatf("fair_resp_id%0d", i + 1 - LAT), 64'(bus.resp_id_o), 64'(seq[i + 1 - LAT]));
      end
    end

    // Mid-stream asynchronous reset, then first grant from index 0.
    chk("pre_reset_valid", 64'(bus.resp_valid_o), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("async_rst_id", 64'(bus.resp_id_o), 64'd0);
    chk("async_rst_product", bus.resp_product_o, 64'd0);
    chk("async_rst_ready", 64'(bus.req_ready_o), 64'd0);
    bus.req_valid_i = 4'b1100;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_grant", 64'(bus.req_ready_o), 64'b0100);
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    repeat (4) @(posedge clk);
    #1;

    // Random stress with the requester hold rule.
    for (int t = 0; t < 10000; t++) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (xfer_seen[k] || !bus.req_valid_i[k]) begin
          bus.req_valid_i[k] = ($urandom_range(0, 2) != 0);
          bus.req_a_i[32*k +: 32] = rnd_op();
          bus.req_b_i[32*k +: 32] = rnd_op();
        end
      end
      bus.resp_ready_i = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      if (xfer_seen[k]) bus.req_valid_i[k] = 1'b0;
    end
    bus.resp_ready_i = 1'b1;
    cyc = 0;
    while ((bus.req_valid_i != '0 || expq.size() != 0) && cyc < 40) begin
      @(posedge clk); #1;
      bus.req_valid_i = bus.req_valid_i & ~xfer_seen;
      cyc++;
    end
    chk("final_queue_empty", 64'(expq.size()), 64'd0);
    chk("final_resp_idle", 64'(bus.resp_valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
